// File: rtl/t_mem_wb.sv
// t_mem_wb: back end of the dual-issue pipe. Performs the data-memory access for both slots,
// resolves branch mispredictions (slot 1 older, higher priority) and produces the WB write-back,
// MEM forwarding and PC-correction/flush signals consumed by the front pipe.
// Optional build macro T_MEM_WB_PERF_EN adds retired-branch and mispredict counters.
module t_mem_wb #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter              MEM_INIT = ""
) (
  input  logic        clk,
  input  logic        rst,
  // Slot 1 (older)
  input  logic [31:0] aluRes1_MEM,
  input  logic [31:0] forwardBRes1_MEM,
  input  logic        MemReadEn1_MEM,
  input  logic        MemWriteEn1_MEM,
  input  logic        MemtoReg1_MEM,
  input  logic        RegWriteEn1_MEM,
  input  logic        jal1_MEM,
  input  logic [4:0]  DestReg1_MEM,
  input  logic [9:0]  return_addr1_MEM,
  input  logic        Branch1_MEM,
  input  logic        taken1_MEM,
  input  logic        pred1_MEM,
  input  logic [9:0]  target1_MEM,
  // Slot 2 (younger)
  input  logic [31:0] aluRes2_MEM,
  input  logic [31:0] forwardBRes2_MEM,
  input  logic        MemReadEn2_MEM,
  input  logic        MemWriteEn2_MEM,
  input  logic        MemtoReg2_MEM,
  input  logic        RegWriteEn2_MEM,
  input  logic        jal2_MEM,
  input  logic [4:0]  DestReg2_MEM,
  input  logic [9:0]  return_addr2_MEM,
  input  logic        Branch2_MEM,
  input  logic        taken2_MEM,
  input  logic        pred2_MEM,
  input  logic [9:0]  target2_MEM,
  // Outputs
  output logic [31:0] aluRes1_MEM_fwd,
  output logic [31:0] aluRes2_MEM_fwd,
  output logic        regWrite1_WB,
  output logic [4:0]  writeReg1_WB,
  output logic [31:0] writeData1_WB,
  output logic [31:0] aluRes1_WB,
  output logic        jal1_WB,
  output logic        regWrite2_WB,
  output logic [4:0]  writeReg2_WB,
  output logic [31:0] writeData2_WB,
  output logic [31:0] aluRes2_WB,
  output logic        jal2_WB,
  output logic        correct_en,
  output logic [9:0]  correction,
  output logic        flush_IFID,
  output logic        flush_IDEX
`ifdef T_MEM_WB_PERF_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] mp_cnt
`endif
);

  logic          mp1, mp2, squash2;
  logic          we1, we2;
  logic [AW-1:0] addr1, addr2;
  logic          unused_addr_bits;

  logic [31:0] mem [DEPTH];
  logic [31:0] load1_q, load2_q;

  logic        memtoreg1_q, memtoreg2_q;
  logic [4:0]  dest1_q, dest2_q;
  logic [9:0]  ra1_q, ra2_q;

  assign addr1 = aluRes1_MEM[AW-1:0];
  assign addr2 = aluRes2_MEM[AW-1:0];
  // Upper address bits are intentionally ignored (word address wraps into the array).
  assign unused_addr_bits = ^{aluRes1_MEM[31:AW], aluRes2_MEM[31:AW]};

  // Branch resolution: slot 1 mispredict wins and kills the younger slot 2.
  always_comb begin
    mp1        = Branch1_MEM & (taken1_MEM != pred1_MEM);
    mp2        = Branch2_MEM & (taken2_MEM != pred2_MEM);
    squash2    = mp1;
    correct_en = mp1 | mp2;
    correction = '0;
    if (mp1) begin
      correction = taken1_MEM ? target1_MEM : return_addr1_MEM;
    end else if (mp2) begin
      correction = taken2_MEM ? target2_MEM : return_addr2_MEM;
    end
    we1 = MemWriteEn1_MEM;
    we2 = MemWriteEn2_MEM & ~squash2;
  end

  assign flush_IFID = correct_en;
  assign flush_IDEX = correct_en;

  // MEM-stage forwarding; loads are never forwarded from here.
  assign aluRes1_MEM_fwd = jal1_MEM ? {22'b0, return_addr1_MEM} : aluRes1_MEM;
  assign aluRes2_MEM_fwd = jal2_MEM ? {22'b0, return_addr2_MEM} : aluRes2_MEM;

  // Data memory: reads see pre-edge contents; slot-2 load bypasses a same-address slot-1 store;
  // slot-2 store is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (MemReadEn1_MEM) load1_q <= mem[addr1];
    if (MemReadEn2_MEM) load2_q <= (we1 && (addr1 == addr2)) ? forwardBRes1_MEM : mem[addr2];
    if (we1) mem[addr1] <= forwardBRes1_MEM;
    if (we2) mem[addr2] <= forwardBRes2_MEM;
  end

  // MEM/WB pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite1_WB <= 1'b0;
      regWrite2_WB <= 1'b0;
      jal1_WB      <= 1'b0;
      jal2_WB      <= 1'b0;
      aluRes1_WB   <= '0;
      aluRes2_WB   <= '0;
      memtoreg1_q  <= 1'b0;
      memtoreg2_q  <= 1'b0;
      dest1_q      <= '0;
      dest2_q      <= '0;
      ra1_q        <= '0;
      ra2_q        <= '0;
    end else begin
      regWrite1_WB <= RegWriteEn1_MEM;
      regWrite2_WB <= RegWriteEn2_MEM & ~squash2;
      jal1_WB      <= jal1_MEM;
      jal2_WB      <= jal2_MEM;
      aluRes1_WB   <= aluRes1_MEM;
      aluRes2_WB   <= aluRes2_MEM;
      memtoreg1_q  <= MemtoReg1_MEM;
      memtoreg2_q  <= MemtoReg2_MEM;
      dest1_q      <= DestReg1_MEM;
      dest2_q      <= DestReg2_MEM;
      ra1_q        <= return_addr1_MEM;
      ra2_q        <= return_addr2_MEM;
    end
  end

  // Write-back mux: jal return address, then load data, then ALU result.
  always_comb begin
    writeReg1_WB  = jal1_WB ? 5'd31 : dest1_q;
    writeReg2_WB  = jal2_WB ? 5'd31 : dest2_q;
    writeData1_WB = jal1_WB ? {22'b0, ra1_q} : (memtoreg1_q ? load1_q : aluRes1_WB);
    writeData2_WB = jal2_WB ? {22'b0, ra2_q} : (memtoreg2_q ? load2_q : aluRes2_WB);
  end

`ifdef T_MEM_WB_PERF_EN
  logic [31:0] br_inc;

  assign br_inc = {31'b0, Branch1_MEM} + {31'b0, Branch2_MEM & ~squash2};

  // Retired-branch and mispredict counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      br_cnt <= br_cnt + br_inc;
      mp_cnt <= mp_cnt + {31'b0, correct_en};
    end
  end
`endif

endmodule

// File: tb/tb_t_mem_wb.sv
// Directed, table-driven bench for t_mem_wb: each vector is one MEM bundle with its expected
// MEM-stage (combinational) and WB-stage (next cycle) results; memory state carries over.
module tb_t_mem_wb;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        mr, mw, m2r, rw, jal;
    logic [4:0]  dst;
    logic [9:0]  ra;
    logic        br, tk, pr;
    logic [9:0]  tg;
  } slot_t;

  typedef struct packed {
    logic [31:0] f1, f2;
    logic        ce;
    logic [9:0]  corr;
    logic        rw1;
    logic [4:0]  wr1;
    logic [31:0] wd1;
    logic        rw2;
    logic [4:0]  wr2;
    logic [31:0] wd2;
  } exp_t;

  typedef struct packed {
    slot_t s1, s2;
    exp_t  ex;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  slot_t in1, in2;

  logic [31:0] fwd1, fwd2, wd1, wd2, alu_wb1, alu_wb2;
  logic        rw1, rw2, jwb1, jwb2, ce, fl1, fl2;
  logic [4:0]  wr1, wr2;
  logic [9:0]  corr;
`ifdef T_MEM_WB_PERF_EN
  logic [31:0] br_cnt, mp_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  t_mem_wb dut (
    .clk(clk), .rst(rst),
    .aluRes1_MEM(in1.alu), .forwardBRes1_MEM(in1.sd), .MemReadEn1_MEM(in1.mr),
    .MemWriteEn1_MEM(in1.mw), .MemtoReg1_MEM(in1.m2r), .RegWriteEn1_MEM(in1.rw),
    .jal1_MEM(in1.jal), .DestReg1_MEM(in1.dst), .return_addr1_MEM(in1.ra),
    .Branch1_MEM(in1.br), .taken1_MEM(in1.tk), .pred1_MEM(in1.pr), .target1_MEM(in1.tg),
    .aluRes2_MEM(in2.alu), .forwardBRes2_MEM(in2.sd), .MemReadEn2_MEM(in2.mr),
    .MemWriteEn2_MEM(in2.mw), .MemtoReg2_MEM(in2.m2r), .RegWriteEn2_MEM(in2.rw),
    .jal2_MEM(in2.jal), .DestReg2_MEM(in2.dst), .return_addr2_MEM(in2.ra),
    .Branch2_MEM(in2.br), .taken2_MEM(in2.tk), .pred2_MEM(in2.pr), .target2_MEM(in2.tg),
    .aluRes1_MEM_fwd(fwd1), .aluRes2_MEM_fwd(fwd2),
    .regWrite1_WB(rw1), .writeReg1_WB(wr1), .writeData1_WB(wd1), .aluRes1_WB(alu_wb1),
    .jal1_WB(jwb1),
    .regWrite2_WB(rw2), .writeReg2_WB(wr2), .writeData2_WB(wd2), .aluRes2_WB(alu_wb2),
    .jal2_WB(jwb2),
    .correct_en(ce), .correction(corr), .flush_IFID(fl1), .flush_IDEX(fl2)
`ifdef T_MEM_WB_PERF_EN
    ,
    .br_cnt(br_cnt), .mp_cnt(mp_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic slot_t s_nop();
    slot_t s;
    s.alu = '0; s.sd = '0; s.mr = 0; s.mw = 0; s.m2r = 0; s.rw = 0; s.jal = 0;
    s.dst = '0; s.ra = '0; s.br = 0; s.tk = 0; s.pr = 0; s.tg = '0;
    return s;
  endfunction

  function automatic slot_t s_alu(input logic [31:0] v, input logic [4:0] d);
    slot_t s = s_nop();
    s.alu = v; s.rw = 1; s.dst = d;
    return s;
  endfunction

  function automatic slot_t s_st(input logic [31:0] a, input logic [31:0] v);
    slot_t s = s_nop();
    s.alu = a; s.sd = v; s.mw = 1;
    return s;
  endfunction

  function automatic slot_t s_ld(input logic [31:0] a, input logic [4:0] d);
    slot_t s = s_nop();
    s.alu = a; s.mr = 1; s.m2r = 1; s.rw = 1; s.dst = d;
    return s;
  endfunction

  function automatic slot_t s_jal(input logic [9:0] ra, input logic [31:0] a);
    slot_t s = s_nop();
    s.jal = 1; s.rw = 1; s.ra = ra; s.alu = a; s.dst = 5'd2;
    return s;
  endfunction

  function automatic slot_t s_br(input logic tk, input logic pr, input logic [9:0] tg,
                                 input logic [9:0] ra);
    slot_t s = s_nop();
    s.br = 1; s.tk = tk; s.pr = pr; s.tg = tg; s.ra = ra;
    return s;
  endfunction

  function automatic exp_t ex(input logic [31:0] f1, input logic [31:0] f2, input logic c,
                              input logic [9:0] cr, input logic r1, input logic [4:0] w1,
                              input logic [31:0] d1, input logic r2, input logic [4:0] w2,
                              input logic [31:0] d2);
    exp_t e;
    e.f1 = f1; e.f2 = f2; e.ce = c; e.corr = cr;
    e.rw1 = r1; e.wr1 = w1; e.wd1 = d1; e.rw2 = r2; e.wr2 = w2; e.wd2 = d2;
    return e;
  endfunction

  task automatic chk_wb_zero(input string tag);
    chk({tag, " rw1"}, {31'b0, rw1}, 0);
    chk({tag, " wr1"}, {27'b0, wr1}, 0);
    chk({tag, " wd1"}, wd1, 0);
    chk({tag, " alu_wb1"}, alu_wb1, 0);
    chk({tag, " jal1_wb"}, {31'b0, jwb1}, 0);
    chk({tag, " rw2"}, {31'b0, rw2}, 0);
    chk({tag, " wr2"}, {27'b0, wr2}, 0);
    chk({tag, " wd2"}, wd2, 0);
    chk({tag, " alu_wb2"}, alu_wb2, 0);
    chk({tag, " jal2_wb"}, {31'b0, jwb2}, 0);
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{s_st(5, 32'hDEADBEEF), s_nop(),
                 ex(5, 0, 0, 0, 0, 0, 5, 0, 0, 0)};
    vecs[1]  = '{s_nop(), s_ld(5, 3),
                 ex(0, 5, 0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF)};
    vecs[2]  = '{s_st(7, 32'h11), s_ld(7, 4),
                 ex(7, 7, 0, 0, 0, 0, 7, 1, 4, 32'h11)};
    vecs[3]  = '{s_ld(7, 5), s_st(7, 32'h22),
                 ex(7, 7, 0, 0, 1, 5, 32'h11, 0, 0, 7)};
    vecs[4]  = '{s_nop(), s_ld(7, 6),
                 ex(0, 7, 0, 0, 0, 0, 0, 1, 6, 32'h22)};
    vecs[5]  = '{s_st(9, 32'hAAAA), s_st(9, 32'hBBBB),
                 ex(9, 9, 0, 0, 0, 0, 9, 0, 0, 9)};
    vecs[6]  = '{s_nop(), s_ld(9, 7),
                 ex(0, 9, 0, 0, 0, 0, 0, 1, 7, 32'hBBBB)};
    vecs[7]  = '{s_br(1, 0, 10'h040, 10'h011), s_st(9, 32'hCCCC),
                 ex(0, 9, 1, 10'h040, 0, 0, 0, 0, 8, 9)};
    vecs[7].s2.rw  = 1;
    vecs[7].s2.dst = 5'd8;
    vecs[8]  = '{s_nop(), s_ld(9, 10),
                 ex(0, 9, 0, 0, 0, 0, 0, 1, 10, 32'hBBBB)};
    vecs[9]  = '{s_alu(32'h1234, 11), s_br(0, 1, 10'h3FF, 10'h013),
                 ex(32'h1234, 0, 1, 10'h013, 1, 11, 32'h1234, 0, 0, 0)};
    vecs[10] = '{s_jal(10'h021, 32'h5555), s_alu(32'h77, 12),
                 ex(32'h21, 32'h77, 0, 0, 1, 31, 32'h21, 1, 12, 32'h77)};
    vecs[11] = '{s_br(0, 1, 10'h100, 10'h0AB), s_br(1, 0, 10'h200, 10'h001),
                 ex(0, 0, 1, 10'h0AB, 0, 0, 0, 0, 0, 0)};
    vecs[12] = '{s_br(1, 1, 10'h050, 10'h022), s_alu(32'h99, 13),
                 ex(0, 32'h99, 0, 0, 0, 0, 0, 1, 13, 32'h99)};
    vecs[13] = '{s_st(32'hFFFFFC0A, 32'h5A5A), s_nop(),
                 ex(32'hFFFFFC0A, 0, 0, 0, 0, 0, 32'hFFFFFC0A, 0, 0, 0)};
    vecs[14] = '{s_nop(), s_ld(32'h00A, 14),
                 ex(0, 32'hA, 0, 0, 0, 0, 0, 1, 14, 32'h5A5A)};
    vecs[15] = '{s_nop(), s_jal(10'h3FF, 1),
                 ex(0, 32'h3FF, 0, 0, 0, 0, 0, 1, 31, 32'h3FF)};
    vecs[16] = '{s_ld(32'h40A, 15), s_nop(),
                 ex(32'h40A, 0, 0, 0, 1, 15, 32'h5A5A, 0, 0, 0)};

    in1 = s_nop();
    in2 = s_nop();
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk_wb_zero("reset");
    chk("reset correct_en", {31'b0, ce}, 0);
`ifdef T_MEM_WB_PERF_EN
    chk("reset br_cnt", br_cnt, 0);
    chk("reset mp_cnt", mp_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in1 = vecs[i].s1;
      in2 = vecs[i].s2;
      #1;
      chk($sformatf("v%0d fwd1", i), fwd1, vecs[i].ex.f1);
      chk($sformatf("v%0d fwd2", i), fwd2, vecs[i].ex.f2);
      chk($sformatf("v%0d correct_en", i), {31'b0, ce}, {31'b0, vecs[i].ex.ce});
      chk($sformatf("v%0d flush_IFID", i), {31'b0, fl1}, {31'b0, vecs[i].ex.ce});
      chk($sformatf("v%0d flush_IDEX", i), {31'b0, fl2}, {31'b0, vecs[i].ex.ce});
      if (vecs[i].ex.ce) chk($sformatf("v%0d correction", i), {22'b0, corr},
                             {22'b0, vecs[i].ex.corr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rw1", i), {31'b0, rw1}, {31'b0, vecs[i].ex.rw1});
      chk($sformatf("v%0d wr1", i), {27'b0, wr1}, {27'b0, vecs[i].ex.wr1});
      chk($sformatf("v%0d wd1", i), wd1, vecs[i].ex.wd1);
      chk($sformatf("v%0d rw2", i), {31'b0, rw2}, {31'b0, vecs[i].ex.rw2});
      chk($sformatf("v%0d wr2", i), {27'b0, wr2}, {27'b0, vecs[i].ex.wr2});
      chk($sformatf("v%0d wd2", i), wd2, vecs[i].ex.wd2);
    end

`ifdef T_MEM_WB_PERF_EN
    // Branches retired: v7, v9, v11 (slot 2 squashed), v12; mispredict cycles: v7, v9, v11.
    chk("perf br_cnt", br_cnt, 4);
    chk("perf mp_cnt", mp_cnt, 3);
`endif

    // Mid-stream reset: WB clears asynchronously, memory survives, next bundle proceeds.
    @(negedge clk);
    in1 = s_jal(10'h02A, 32'h0);
    in2 = s_alu(32'h66, 9);
    @(posedge clk);
    #1;
    chk("pre-reset wr1", {27'b0, wr1}, 31);
    chk("pre-reset jal1_wb", {31'b0, jwb1}, 1);
    chk("pre-reset alu_wb2", alu_wb2, 32'h66);
    #2 rst = 1'b0;
    #1;
    chk_wb_zero("midreset");
`ifdef T_MEM_WB_PERF_EN
    chk("midreset br_cnt", br_cnt, 0);
    chk("midreset mp_cnt", mp_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset wr1", {27'b0, wr1}, 31);
    chk("post-reset wd1", wd1, 32'h2A);
    chk("post-reset rw2", {31'b0, rw2}, 1);
    chk("post-reset wd2", wd2, 32'h66);
    @(negedge clk);
    in1 = s_ld(5, 1);
    in2 = s_nop();
    @(posedge clk);
    #1;
    chk("post-reset mem kept", wd1, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
